shared_divider: RTL and testbench

- Sequential radix-2 restoring unsigned divider shared by the bike-computer arithmetic stages (average speed, current speed).
- Sits directly downstream of those stages. It consumes their dividend/divisor registers and returns quotient with Busy/Ready status.
- A select input picks which of two client operand sets is latched at start. One division is in flight at a time.

---
 rtl/bike_pkg.sv | 14 +
 rtl/shared_divider_if.sv | 26 ++
 rtl/shared_divider_div_step.sv | 19 +
 rtl/shared_divider.sv | 87 ++++++++
 tb/tb_shared_divider.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/bike_pkg.sv
// rtl/bike_pkg.sv - shared constants and state encoding for the bike-computer arithmetic
package bike_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/shared_divider_if.sv
// rtl/shared_divider_if.sv - operand/result bundle between the speed stages and the shared divider
interface shared_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             select;
  logic [WIDTH-1:0] dividend0;
  logic [WIDTH-1:0] divisor0;
  logic [WIDTH-1:0] dividend1;
  logic [WIDTH-1:0] divisor1;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             Busy;
  logic             Ready;
  logic             div_zero;

  modport master (
    output start, select, dividend0, divisor0, dividend1, divisor1,
    input  quotient, remainder, Busy, Ready, div_zero
  );

  modport slave (
    input  start, select, dividend0, divisor0, dividend1, divisor1,
    output quotient, remainder, Busy, Ready, div_zero
  );
endinterface

// File: rtl/shared_divider_div_step.sv
// rtl/shared_divider_div_step.sv - one combinational restoring-division iteration
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  // One extra bit carries the shift-out so the compare never wraps.
  logic [WIDTH:0] shifted;

  always_comb begin
    shifted  = {rem, dvd_bit};
    q_bit    = (shifted >= {1'b0, divisor});
    rem_next = q_bit ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/shared_divider.sv
// rtl/shared_divider.sv - radix-2 restoring unsigned divider shared by two client stages
module shared_divider
  import bike_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 5
) (
  input logic             clk,
  input logic             rst,
  shared_divider_if.slave div_if
);
  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] sel_dividend;
  logic [WIDTH-1:0] sel_divisor;

  assign sel_dividend = div_if.select ? div_if.dividend1 : div_if.dividend0;
  assign sel_divisor  = div_if.select ? div_if.divisor1  : div_if.divisor0;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_bit  (dvd_q[WIDTH-1]),
    .divisor  (dvs),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // dvd_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= DIV_IDLE;
      count            <= '0;
      dvd_q            <= '0;
      dvs              <= '0;
      rem              <= '0;
      div_if.quotient  <= '0;
      div_if.remainder <= '0;
      div_if.Busy      <= 1'b0;
      div_if.Ready     <= 1'b0;
      div_if.div_zero  <= 1'b0;
    end else begin
      div_if.Ready <= 1'b0;
      case (state)
        DIV_IDLE, DIV_DONE: begin
          if (div_if.start) begin
            dvd_q       <= sel_dividend;
            dvs         <= sel_divisor;
            rem         <= '0;
            count       <= '0;
            state       <= DIV_CALC;
            div_if.Busy <= (sel_divisor != '0);
          end else begin
            state <= DIV_IDLE;
          end
        end
        DIV_CALC: begin
          // A zero divisor settles in one pass with Busy kept low.
          if (dvs == '0) begin
            div_if.quotient  <= '1;
            div_if.remainder <= dvd_q;
            div_if.div_zero  <= 1'b1;
            div_if.Ready     <= 1'b1;
            state            <= DIV_DONE;
          end else begin
            dvd_q <= {dvd_q[WIDTH-2:0], step_q};
            rem   <= step_rem;
            count <= count + 1'b1;
            if (count == CNT_W'(WIDTH - 1)) begin
              div_if.quotient  <= {dvd_q[WIDTH-2:0], step_q};
              div_if.remainder <= step_rem;
              div_if.div_zero  <= 1'b0;
              div_if.Busy      <= 1'b0;
              div_if.Ready     <= 1'b1;
              state            <= DIV_DONE;
            end
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shared_divider.sv
// tb/tb_shared_divider.sv - scoreboard bench for shared_divider
module tb_shared_divider;
  import bike_pkg::*;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  logic [15:0] st_rem, st_dvs, st_rem_next;
  logic        st_bit, st_q;

  shared_divider_if #(.WIDTH(16)) dif ();

  shared_divider #(.WIDTH(16), .CNT_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif.slave)
  );

  div_step #(.WIDTH(16)) u_step_iso (
    .rem      (st_rem),
    .dvd_bit  (st_bit),
    .divisor  (st_dvs),
    .rem_next (st_rem_next),
    .q_bit    (st_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    if (b == 16'd0) begin
      e.q = 16'hFFFF; e.r = a; e.dz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Drives start for one edge from the current negedge; returns on the following negedge.
  task automatic issue(input logic sel, input logic [15:0] a0, input logic [15:0] b0,
                       input logic [15:0] a1, input logic [15:0] b1, input bit push);
    dif.select    = sel;
    dif.dividend0 = a0; dif.divisor0 = b0;
    dif.dividend1 = a1; dif.divisor1 = b1;
    dif.start     = 1'b1;
    if (push) sb.push_back(sel ? model(a1, b1) : model(a0, b0));
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  task automatic start_div(input logic sel, input logic [15:0] a0, input logic [15:0] b0,
                           input logic [15:0] a1, input logic [15:0] b1);
    @(negedge clk);
    issue(sel, a0, b0, a1, b1, 1'b1);
  endtask

  // Counts sample points from the first negedge after the accepting edge until Ready.
  task automatic wait_ready(input string tag, output int lat, output int busy_n);
    exp_t e;
    lat = 1; busy_n = 0;
    while (!dif.Ready && lat < 40) begin
      if (dif.Busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_ready_seen"}, 32'(dif.Ready), 32'd1);
    check({tag, "_busy_at_ready"}, 32'(dif.Busy), 32'd0);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_quotient"}, 32'(dif.quotient), 32'(e.q));
      check({tag, "_remainder"}, 32'(dif.remainder), 32'(e.r));
      check({tag, "_div_zero"}, 32'(dif.div_zero), 32'(e.dz));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy_n, pulses;
    logic [15:0] ra, rb;
    logic [15:0] st_tab [4][3];
    logic [1:0]  st_exp [4];
    n_checks = 0; n_fail = 0;
    dif.start = 1'b0; dif.select = 1'b0;
    dif.dividend0 = '0; dif.divisor0 = '0; dif.dividend1 = '0; dif.divisor1 = '0;
    st_rem = '0; st_bit = 1'b0; st_dvs = 16'd1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_quotient", 32'(dif.quotient), 32'd0);
    check("rst_remainder", 32'(dif.remainder), 32'd0);
    check("rst_busy", 32'(dif.Busy), 32'd0);
    check("rst_ready", 32'(dif.Ready), 32'd0);
    check("rst_div_zero", 32'(dif.div_zero), 32'd0);
    rst = 1'b0;

    // {rem, bit, divisor} -> {q_bit, rem_next==expected}
    st_tab[0] = '{16'd5, 16'd1, 16'd7};      st_exp[0] = 2'b1;
    st_tab[1] = '{16'd2, 16'd1, 16'd7};      st_exp[1] = 2'b0;
    st_tab[2] = '{16'hFFFE, 16'd1, 16'hFFFF}; st_exp[2] = 2'b1;
    st_tab[3] = '{16'd3, 16'd0, 16'd6};      st_exp[3] = 2'b1;
    for (int i = 0; i < 4; i++) begin
      st_rem = st_tab[i][0]; st_bit = st_tab[i][1][0]; st_dvs = st_tab[i][2];
      #1;
      check("step_qbit", 32'(st_q), 32'(st_exp[i][0]));
      check("step_rem", 32'(st_rem_next),
            32'(st_exp[i][0] ? ({st_tab[i][0], st_tab[i][1][0]} - st_tab[i][2])
                             : {st_tab[i][0], st_tab[i][1][0]}));
    end

    start_div(1'b0, 16'd36000, 16'd13, 16'd0, 16'd0);
    wait_ready("t36000", lat, busy_n);
    check("t36000_latency", 32'(lat), 32'd17);
    check("t36000_busy_cycles", 32'(busy_n), 32'd16);

    start_div(1'b1, 16'd100, 16'd7, 16'd65535, 16'd1);
    wait_ready("tsel1", lat, busy_n);

    start_div(1'b0, 16'd100, 16'd0, 16'd5, 16'd5);
    wait_ready("tdz", lat, busy_n);
    check("tdz_latency", 32'(lat), 32'd2);
    check("tdz_busy_cycles", 32'(busy_n), 32'd0);
    @(negedge clk);
    check("tdz_ready_drop", 32'(dif.Ready), 32'd0);
    check("tdz_q_held", 32'(dif.quotient), 32'hFFFF);
    check("tdz_dz_held", 32'(dif.div_zero), 32'd1);

    start_div(1'b0, 16'd6000, 16'd60, 16'd0, 16'd0);
    repeat (4) @(negedge clk);
    issue(1'b0, 16'd9, 16'd3, 16'd0, 16'd0, 1'b0);
    wait_ready("tignore", lat, busy_n);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (dif.Ready) pulses++;
    end
    check("tignore_no_second_ready", 32'(pulses), 32'd0);

    start_div(1'b0, 16'd6000, 16'd60, 16'd0, 16'd0);
    wait_ready("tb2b_first", lat, busy_n);
    issue(1'b0, 16'd9, 16'd3, 16'd0, 16'd0, 1'b1);
    check("tb2b_busy_after_accept", 32'(dif.Busy), 32'd1);
    check("tb2b_first_held", 32'(dif.quotient), 32'd100);
    wait_ready("tb2b_second", lat, busy_n);
    check("tb2b_latency", 32'(lat), 32'd17);

    start_div(1'b0, 16'd50000, 16'd7, 16'd0, 16'd0);
    void'(sb.pop_back());
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("trst_busy", 32'(dif.Busy), 32'd0);
    check("trst_ready", 32'(dif.Ready), 32'd0);
    check("trst_quotient", 32'(dif.quotient), 32'd0);
    check("trst_remainder", 32'(dif.remainder), 32'd0);
    start_div(1'b0, 16'd50000, 16'd7, 16'd0, 16'd0);
    wait_ready("trst_after", lat, busy_n);
    check("trst_after_latency", 32'(lat), 32'd17);

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = (i == 5) ? 16'hFFFF : 16'($urandom_range(1, 65535) >> (i * 2));
      if (rb == 16'd0) rb = 16'd1;
      start_div(i[0], ra ^ 16'h5A5A, rb ^ 16'h0F0F, ra, rb);
      wait_ready("trand", lat, busy_n);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
